// File: rtl/fifo_stagger_ctrl.sv
// rtl/fifo_stagger_ctrl.sv - per-lane enable sequencer for a weight FIFO bank; optional FIFO_STAGGER_STATS_EN adds stall_cnt
module fifo_stagger_ctrl #(
  parameter int LANES = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             hold,
  input  logic             abort,
  output logic [LANES-1:0] fifo_en,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef FIFO_STAGGER_STATS_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam int TW = $clog2(LANES + DEPTH);

  localparam logic [1:0] MODE_LOAD  = 2'b00;
  localparam logic [1:0] MODE_STAG  = 2'b01;
  localparam logic [1:0] MODE_RSTAG = 2'b10;
  localparam logic [1:0] MODE_ILL   = 2'b11;

  // Last value of t in a run; t never exceeds these, so it cannot wrap.
  localparam logic [TW-1:0] LAST_LOAD = TW'(DEPTH - 1);
  localparam logic [TW-1:0] LAST_STAG = TW'(DEPTH + LANES - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [1:0]    mode_q, mode_d;
  logic          err_q, err_d;
  logic          start_ok;
  logic [TW-1:0] t_last;

  // A run is only accepted from IDLE with a legal mode and no abort.
  assign start_ok = (state_q == S_IDLE) && start && !abort && (mode != MODE_ILL);
  assign t_last   = (mode_q == MODE_LOAD) ? LAST_LOAD : LAST_STAG;

  // State, counter, captured mode and error pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      mode_q  <= MODE_LOAD;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: abort wins over hold and start; hold freezes RUN.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    mode_d  = mode_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        err_d = start && !abort && (mode == MODE_ILL);
        if (start_ok) begin
          state_d = S_RUN;
          t_d     = '0;
          mode_d  = mode;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          t_d     = '0;
        end else if (!hold) begin
          if (t_q == t_last) begin
            state_d = S_DONE;
            t_d     = '0;
          end else begin
            t_d = t_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        t_d     = '0;
      end
    endcase
  end

  // Lane i is open for DEPTH cycles starting at its stagger offset.
  always_comb begin
    int t_int;
    int lo;
    fifo_en = '0;
    t_int   = int'(t_q);
    lo      = 0;
    if (state_q == S_RUN && !hold && !abort) begin
      for (int i = 0; i < LANES; i++) begin
        case (mode_q)
          MODE_STAG:  lo = i;
          MODE_RSTAG: lo = LANES - 1 - i;
          default:    lo = 0;
        endcase
        fifo_en[i] = (t_int >= lo) && (t_int < lo + DEPTH);
      end
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE) && !abort;
  assign err  = err_q;

`ifdef FIFO_STAGGER_STATS_EN
  // Saturating count of stalled RUN cycles, restarted by each accepted run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (start_ok) begin
      stall_cnt <= '0;
    end else if (state_q == S_RUN && hold && !abort && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stagger_ctrl.sv
// tb/tb_fifo_stagger_ctrl.sv - self-checking bench for fifo_stagger_ctrl against a behavioural model
module tb_fifo_stagger_ctrl;

  localparam int L = 16;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         hold = 1'b0;
  logic         abort = 1'b0;
  logic [L-1:0] fifo_en;
  logic         busy;
  logic         done;
  logic         err;
`ifdef FIFO_STAGGER_STATS_EN
  logic [15:0]  stall_cnt;
`endif

  fifo_stagger_ctrl #(.LANES(L), .DEPTH(D)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mode    (mode),
    .hold    (hold),
    .abort   (abort),
    .fifo_en (fifo_en),
    .busy    (busy),
    .done    (done),
    .err     (err)
`ifdef FIFO_STAGGER_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: phase 0 idle, 1 running, 2 finishing; m_t counts progressed run cycles.
  int m_phase = 0;
  int m_t = 0;
  int m_mode = 0;
  int m_err = 0;
  int m_stall = 0;
  int lane_cnt[L];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [L-1:0] bitrev(input logic [L-1:0] v);
    logic [L-1:0] r;
    for (int i = 0; i < L; i++) r[i] = v[L-1-i];
    return r;
  endfunction

  // Window of lanes open at progress tt: lanes (tt-D, tt] for forward stagger.
  function automatic logic [L-1:0] model_en(input int ph, input int tt, input int md,
                                            input logic h, input logic a);
    logic [63:0] upper;
    logic [63:0] lower;
    logic [63:0] win;
    int lo;
    if (ph != 1 || h || a) return '0;
    if (md == 0) return '1;
    upper = (64'd1 << (tt + 1)) - 64'd1;
    lo = tt + 1 - D;
    lower = (lo > 0) ? ((64'd1 << lo) - 64'd1) : 64'd0;
    win = upper & ~lower;
    if (md == 1) return win[L-1:0];
    return bitrev(win[L-1:0]);
  endfunction

  function automatic int total_of(input int md);
    return (md == 0) ? D : D + L - 1;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_t = 0;
    m_mode = 0;
    m_err = 0;
    m_stall = 0;
    for (int i = 0; i < L; i++) lane_cnt[i] = 0;
  endtask

  // Compare every DUT output against the model for the current inputs.
  task automatic compare_all();
    chk("fifo_en", 32'(fifo_en), 32'(model_en(m_phase, m_t, m_mode, hold, abort)));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("done", 32'(done), 32'(m_phase == 2 && !abort));
    chk("err", 32'(err), 32'(m_err));
`ifdef FIFO_STAGGER_STATS_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
    if (m_phase == 1)
      for (int i = 0; i < L; i++) lane_cnt[i] += int'(fifo_en[i]);
  endtask

  task automatic model_step();
    int ok;
    case (m_phase)
      0: begin
        m_err = (start && !abort && mode == 2'b11) ? 1 : 0;
        if (start && !abort && mode != 2'b11) begin
          m_phase = 1;
          m_t = 0;
          m_mode = int'(mode);
          m_stall = 0;
          for (int i = 0; i < L; i++) lane_cnt[i] = 0;
        end
      end
      1: begin
        m_err = 0;
        if (abort) begin
          m_phase = 0;
        end else if (hold) begin
          if (m_stall < 65535) m_stall++;
        end else if (m_t == total_of(m_mode) - 1) begin
          m_phase = 2;
          ok = 1;
          for (int i = 0; i < L; i++) if (lane_cnt[i] != D) ok = 0;
          chk("lane_enable_count", 32'(ok), 32'd1);
        end else begin
          m_t++;
        end
      end
      default: begin
        m_err = 0;
        m_phase = 0;
      end
    endcase
  endtask

  task automatic drive(input logic s, input logic [1:0] m, input logic h, input logic a);
    @(negedge clk);
    start = s;
    mode = m;
    hold = h;
    abort = a;
    #1;
    compare_all();
  endtask

  task automatic adv();
    @(posedge clk);
    model_step();
  endtask

  task automatic cyc(input logic s, input logic [1:0] m, input logic h, input logic a);
    drive(s, m, h, a);
    adv();
  endtask

  initial begin
    model_reset();
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_fifo_en", 32'(fifo_en), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Model pins against hand-computed values
    chk("model_stag_t0", 32'(model_en(1, 0, 1, 1'b0, 1'b0)), 32'h0001);
    chk("model_stag_t16", 32'(model_en(1, 16, 1, 1'b0, 1'b0)), 32'hFFFE);
    chk("model_rstag_t30", 32'(model_en(1, 30, 2, 1'b0, 1'b0)), 32'h0001);

    // LOAD
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 2'b00, 1'b0, 1'b0);
      chk("load_en", 32'(fifo_en), 32'hFFFF);
      adv();
    end
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    chk("load_done", 32'(done), 32'h1);
    chk("load_done_en", 32'(fifo_en), 32'h0);
    adv();
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    chk("load_idle_busy", 32'(busy), 32'h0);
    adv();

    // STAGGER
    cyc(1'b1, 2'b01, 1'b0, 1'b0);
    for (int k = 0; k < 31; k++) begin
      drive(1'b0, 2'b00, 1'b0, 1'b0);
      if (k == 0)  chk("stag_t0", 32'(fifo_en), 32'h0001);
      if (k == 1)  chk("stag_t1", 32'(fifo_en), 32'h0003);
      if (k == 15) chk("stag_t15", 32'(fifo_en), 32'hFFFF);
      if (k == 16) chk("stag_t16", 32'(fifo_en), 32'hFFFE);
      if (k == 30) chk("stag_t30", 32'(fifo_en), 32'h8000);
      adv();
    end
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    chk("stag_done_cycle32", 32'(done), 32'h1);
    adv();

    // RSTAGGER
    cyc(1'b1, 2'b10, 1'b0, 1'b0);
    for (int k = 0; k < 31; k++) begin
      drive(1'b0, 2'b00, 1'b0, 1'b0);
      if (k == 0)  chk("rstag_t0", 32'(fifo_en), 32'h8000);
      if (k == 15) chk("rstag_t15", 32'(fifo_en), 32'hFFFF);
      if (k == 30) chk("rstag_t30", 32'(fifo_en), 32'h0001);
      adv();
    end
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    chk("rstag_done", 32'(done), 32'h1);
    adv();

    // STAGGER with a 3-cycle hold at t=5
    cyc(1'b1, 2'b01, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b0, 2'b00, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 2'b00, 1'b1, 1'b0);
      chk("hold_en", 32'(fifo_en), 32'h0);
      adv();
    end
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    chk("hold_resume", 32'(fifo_en), 32'h003F);
    adv();
    for (int k = 6; k < 31; k++) cyc(1'b0, 2'b00, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    chk("hold_done", 32'(done), 32'h1);
`ifdef FIFO_STAGGER_STATS_EN
    chk("hold_stall_cnt", 32'(stall_cnt), 32'd3);
`endif
    adv();

    // abort at t=10 of LOAD, restart the following cycle
    cyc(1'b1, 2'b00, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) cyc(1'b0, 2'b00, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 1'b0, 1'b1);
    chk("abort_en", 32'(fifo_en), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    adv();
    drive(1'b1, 2'b00, 1'b0, 1'b0);
    chk("abort_idle", 32'(busy), 32'h0);
    adv();
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    chk("abort_restart", 32'(busy), 32'h1);
    adv();
    for (int k = 1; k < 17; k++) cyc(1'b0, 2'b00, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 1'b0, 1'b0);

    // Illegal mode
    cyc(1'b1, 2'b11, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    chk("illegal_err", 32'(err), 32'h1);
    chk("illegal_busy", 32'(busy), 32'h0);
    adv();
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    chk("illegal_err_clear", 32'(err), 32'h0);
    adv();

    // Asynchronous reset at t=7 of STAGGER
    cyc(1'b1, 2'b01, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) cyc(1'b0, 2'b00, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    chk("pre_reset_en", 32'(fifo_en), 32'h00FF);
    #1;
    reset = 1'b0;
    #1;
    chk("async_reset_en", 32'(fifo_en), 32'h0);
    chk("async_reset_busy", 32'(busy), 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Randomised traffic
    for (int n = 0; n < 4000; n++) begin
      cyc(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
